// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard control unit: state encoding,
// register-index width, default counter width and control-output bundles.
package hazard_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int COUNT_W_DEFAULT = 32;

    // Each state records which action the unit took in the previous cycle.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10,
        ST_MEM_WAIT = 2'b11
    } hcu_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
    } hcu_ctrl_t;

    localparam hcu_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1,
                                          ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam hcu_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1,
                                          ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam hcu_ctrl_t CTRL_LU     = '{pc_write: 1'b0, ifid_write: 1'b0,
                                          ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam hcu_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0,
                                          ifid_flush: 1'b0, idex_bubble: 1'b0};
    // Held while reset is asserted: nothing advances and the pipe is filled with NOPs.
    localparam hcu_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0,
                                          ifid_flush: 1'b1, idex_bubble: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on enable and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: decodes stall/flush/freeze enables each cycle and
// keeps saturating counts of stall cycles and branch flushes.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 idex_mem_read,
    input  logic [REG_IDX_W-1:0] idex_rd,
    input  logic [REG_IDX_W-1:0] ifid_rs1,
    input  logic [REG_IDX_W-1:0] ifid_rs2,
    input  logic                 branch_taken,
    input  logic                 mem_busy,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic [1:0]           state,
    output logic [COUNT_W-1:0]   stall_count,
    output logic [COUNT_W-1:0]   flush_count
);

    hcu_state_e state_q;
    hcu_state_e state_d;
    hcu_ctrl_t  ctrl;
    logic       load_use;
    logic       stall_en;
    logic       flush_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // rs2 is compared even for instructions that do not read it; a spurious
    // stall costs one cycle, a missed one corrupts data.
    always_comb begin
        load_use = idex_mem_read
                 && (idex_rd != '0)
                 && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2))
                 && (state_q != ST_BR_FLUSH);
        state_d  = ST_RUN;
        ctrl     = CTRL_NORMAL;
        stall_en = 1'b0;
        flush_en = 1'b0;
        if (!reset) begin
            ctrl = CTRL_RESET;
        end else if (mem_busy) begin
            ctrl     = CTRL_FREEZE;
            state_d  = ST_MEM_WAIT;
            stall_en = 1'b1;
        end else if (branch_taken) begin
            ctrl     = CTRL_FLUSH;
            state_d  = ST_BR_FLUSH;
            flush_en = 1'b1;
        end else if (load_use) begin
            ctrl     = CTRL_LU;
            state_d  = ST_LU_STALL;
            stall_en = 1'b1;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign state       = state_q;

    sat_counter #(.WIDTH(COUNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(COUNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios plus random traffic against a behavioural model.
module tb_hazard_control_unit;

    logic       clk;
    logic       reset;
    logic       idex_mem_read;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       branch_taken;
    logic       mem_busy;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  state;
    logic [31:0] stall_count, flush_count;

    logic        pc_write_n, ifid_write_n, ifid_flush_n, idex_bubble_n;
    logic [1:0]  state_n;
    logic [3:0]  stall_count_n, flush_count_n;

    int total = 0;
    int bad   = 0;

    // Model: last action taken (0 normal, 1 load-use, 2 branch, 3 mem freeze) and counts.
    int     m_last;
    longint m_stall_w, m_flush_w, m_stall_n, m_flush_n;

    hazard_control_unit u_dut (
        .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_control_unit #(.COUNT_W(4)) u_dut_n (
        .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pc_write_n), .ifid_write(ifid_write_n),
        .ifid_flush(ifid_flush_n), .idex_bubble(idex_bubble_n), .state(state_n),
        .stall_count(stall_count_n), .flush_count(flush_count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_action(input logic mr, input logic [4:0] rd, r1, r2,
                                        input logic bt, mb);
        if (mb) return 3;
        if (bt) return 2;
        if (mr && rd != 0 && (rd == r1 || rd == r2) && m_last != 2) return 1;
        return 0;
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_bubble}
    function automatic logic [3:0] ctrl_of(input int act);
        case (act)
            3:       return 4'b0000;
            2:       return 4'b1111;
            1:       return 4'b0001;
            default: return 4'b1100;
        endcase
    endfunction

    task automatic check_all(input logic [3:0] e);
        chk("pc_write",    64'(pc_write),    64'(e[3]));
        chk("ifid_write",  64'(ifid_write),  64'(e[2]));
        chk("ifid_flush",  64'(ifid_flush),  64'(e[1]));
        chk("idex_bubble", 64'(idex_bubble), 64'(e[0]));
        chk("narrow_ctrl", 64'({pc_write_n, ifid_write_n, ifid_flush_n, idex_bubble_n}), 64'(e));
        chk("state",       64'(state),         64'(m_last));
        chk("stall_w",     64'(stall_count),   64'(m_stall_w));
        chk("flush_w",     64'(flush_count),   64'(m_flush_w));
        chk("stall_n",     64'(stall_count_n), 64'(m_stall_n));
        chk("flush_n",     64'(flush_count_n), 64'(m_flush_n));
    endtask

    // Apply one cycle of inputs, check the combinational decode mid-cycle, then advance the model.
    task automatic step(input logic mr, input logic [4:0] rd, r1, r2, input logic bt, mb);
        int act;
        idex_mem_read = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
        branch_taken = bt; mem_busy = mb;
        act = model_action(mr, rd, r1, r2, bt, mb);
        @(negedge clk);
        check_all(ctrl_of(act));
        @(posedge clk);
        m_last = act;
        if (act == 1 || act == 3) begin
            if (m_stall_w < 64'hFFFF_FFFF) m_stall_w++;
            if (m_stall_n < 15) m_stall_n++;
        end
        if (act == 2) begin
            if (m_flush_w < 64'hFFFF_FFFF) m_flush_w++;
            if (m_flush_n < 15) m_flush_n++;
        end
        #1;
    endtask

    // Assert reset away from a clock edge and check its effect before any edge arrives.
    task automatic do_reset();
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        branch_taken = 0; mem_busy = 0;
        reset = 1'b0;
        m_last = 0; m_stall_w = 0; m_flush_w = 0; m_stall_n = 0; m_flush_n = 0;
        #1;
        check_all(4'b0011);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        branch_taken = 0; mem_busy = 0;
        m_last = 0; m_stall_w = 0; m_flush_w = 0; m_stall_n = 0; m_flush_n = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Load-use hazard on rs1, then an idle cycle showing the recorded state.
        step(1, 5, 5, 7, 0, 0);
        chk("lu_state", 64'(state), 64'd1);
        chk("lu_stall_cnt", 64'(stall_count), 64'd1);
        step(0, 0, 0, 0, 0, 0);

        // Load into x0 never stalls.
        step(1, 0, 3, 0, 0, 0);
        chk("x0_state", 64'(state), 64'd0);
        chk("x0_stall_cnt", 64'(stall_count), 64'd1);

        // Reset landing between edges while in LU_STALL.
        step(1, 9, 2, 9, 0, 0);
        chk("pre_rst_state", 64'(state), 64'd1);
        do_reset();
        step(0, 0, 0, 0, 0, 0);

        // Branch and load-use together: branch wins; held hazard then suppressed.
        do_reset();
        step(1, 5, 5, 0, 1, 0);
        chk("br_lu_flush_cnt", 64'(flush_count), 64'd1);
        chk("br_lu_stall_cnt", 64'(stall_count), 64'd0);
        step(1, 5, 5, 0, 0, 0);
        chk("br_after_state", 64'(state), 64'd0);
        chk("br_after_stall", 64'(stall_count), 64'd0);

        // Memory freeze over a taken branch for three cycles.
        do_reset();
        repeat (3) step(0, 0, 0, 0, 1, 1);
        chk("mw_state", 64'(state), 64'd3);
        chk("mw_stall_cnt", 64'(stall_count), 64'd3);
        chk("mw_flush_cnt", 64'(flush_count), 64'd0);

        // Saturation of the 4-bit instance over 20 load-use cycles.
        do_reset();
        repeat (20) step(1, 6, 1, 6, 0, 0);
        chk("sat_n", 64'(stall_count_n), 64'hF);
        chk("sat_w", 64'(stall_count), 64'd20);

        // Random traffic with small register indices to make hazards frequent.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 6) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
